// File: rtl/permutation_round_engine_pkg.sv
// Shared Ascon types, round-constant table and rotate helper for the
// permutation round engine and its combinational layers.
package ascon_pack;

  localparam int NB_WORDS = 5;
  localparam int WORD_W   = 64;
  localparam int NB_RC    = 12;

  typedef logic [NB_WORDS-1:0][WORD_W-1:0] type_state;
  typedef logic [3:0]                      type_round_idx;

  typedef enum logic {IDLE, RUN} type_fsm;

  localparam type_round_idx PA_START_IDX = 4'd0;
  localparam type_round_idx PB_START_IDX = 4'd6;

  localparam logic [7:0] round_constant [0:NB_RC-1] = '{
    8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B
  };

  // Indices 12..15 are unreachable; they read as zero.
  function automatic logic [7:0] rc_lookup(input type_round_idx idx);
    logic [7:0] rc;
    rc = 8'h00;
    if (idx < type_round_idx'(NB_RC)) rc = round_constant[int'(idx)];
    return rc;
  endfunction

  function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

endpackage

// File: rtl/diffusion_layer.sv
// Ascon pl: per-word linear diffusion with two fixed rotations each.
module diffusion_layer
  import ascon_pack::*;
(
  input  type_state state_in,
  output type_state state_out
);
  assign state_out[0] = state_in[0] ^ ror(state_in[0], 19) ^ ror(state_in[0], 28);
  assign state_out[1] = state_in[1] ^ ror(state_in[1], 61) ^ ror(state_in[1], 39);
  assign state_out[2] = state_in[2] ^ ror(state_in[2],  1) ^ ror(state_in[2],  6);
  assign state_out[3] = state_in[3] ^ ror(state_in[3], 10) ^ ror(state_in[3], 17);
  assign state_out[4] = state_in[4] ^ ror(state_in[4],  7) ^ ror(state_in[4], 41);
endmodule

// File: rtl/substitution_column.sv
// Ascon 5-bit S-box on one bit column; bit 4 carries x0, bit 0 carries x4.
module substitution_column (
  input  logic [4:0] col_in,
  output logic [4:0] col_out
);
  logic a0, a1, a2, a3, a4;
  logic b0, b1, b2, b3, b4;
  logic c0, c1, c2, c3, c4;

  assign {a0, a1, a2, a3, a4} = col_in;

  assign b0 = a0 ^ a4;
  assign b1 = a1;
  assign b2 = a2 ^ a1;
  assign b3 = a3;
  assign b4 = a4 ^ a3;

  // chi-like step: each bit picks up (~next & next-next)
  assign c0 = b0 ^ (~b1 & b2);
  assign c1 = b1 ^ (~b2 & b3);
  assign c2 = b2 ^ (~b3 & b4);
  assign c3 = b3 ^ (~b4 & b0);
  assign c4 = b4 ^ (~b0 & b1);

  assign col_out = {c0 ^ c4, c1 ^ c0, ~c2, c3 ^ c2, c4};
endmodule

// File: rtl/substitution_layer.sv
// Ascon ps: 64 independent S-box columns across the five state words.
module substitution_layer
  import ascon_pack::*;
#(
  parameter int NUM_LANES = WORD_W
) (
  input  type_state state_in,
  output type_state state_out
);
  logic [NUM_LANES-1:0][4:0] col_in, col_out;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign col_in[l] = {state_in[0][l], state_in[1][l], state_in[2][l],
                        state_in[3][l], state_in[4][l]};

    substitution_column u_col (
      .col_in  (col_in[l]),
      .col_out (col_out[l])
    );

    assign {state_out[0][l], state_out[1][l], state_out[2][l],
            state_out[3][l], state_out[4][l]} = col_out[l];
  end
endmodule

// File: rtl/permutation_round_engine.sv
// Iterative Ascon permutation: one pc/ps/pl round per clock, p^a or p^b per job,
// result held in the state register until the next accepted start.
module permutation_round_engine
  import ascon_pack::*;
#(
  parameter int NB_ROUNDS_MAX = 12
) (
  input  logic      clock_i,
  input  logic      reset_i,
  input  logic      start_i,
  input  logic      rounds12_i,
  input  type_state state_i,
  output type_state state_o,
  output logic      busy_o,
  output logic      done_o
);
  type_fsm       fsm_q;
  type_round_idx idx_q;
  type_state     st_q, st_pc, st_ps, st_pl;
  logic          last_round;

  always_comb begin
    st_pc          = st_q;
    st_pc[2][7:0]  = st_q[2][7:0] ^ rc_lookup(idx_q);
  end

  substitution_layer u_ps (
    .state_in  (st_pc),
    .state_out (st_ps)
  );

  diffusion_layer u_pl (
    .state_in  (st_ps),
    .state_out (st_pl)
  );

  // Both p^a and p^b end on the final table entry; only the start index differs.
  assign last_round = (idx_q == type_round_idx'(NB_ROUNDS_MAX - 1));

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      fsm_q  <= IDLE;
      idx_q  <= '0;
      st_q   <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            st_q   <= state_i;
            idx_q  <= rounds12_i ? PA_START_IDX : PB_START_IDX;
            fsm_q  <= RUN;
            busy_o <= 1'b1;
          end
        end
        RUN: begin
          st_q  <= st_pl;
          idx_q <= idx_q + 4'd1;
          if (last_round) begin
            fsm_q  <= IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign state_o = st_q;
endmodule

// File: tb/tb_permutation_round_engine.sv
// Scoreboard bench for permutation_round_engine against a word-level Ascon model.
module tb_permutation_round_engine;
  import ascon_pack::*;

  logic      clk = 1'b0;
  logic      rst, start, r12;
  type_state sin, sout;
  logic      busy, done;

  typedef struct {
    type_state st;
    int        n;
  } exp_t;

  exp_t q[$];
  int   checks = 0, errors = 0;
  int   bcnt = 0;
  bit   prev_done = 1'b0;
  exp_t e;

  permutation_round_engine dut (
    .clock_i    (clk),
    .reset_i    (rst),
    .start_i    (start),
    .rounds12_i (r12),
    .state_i    (sin),
    .state_o    (sout),
    .busy_o     (busy),
    .done_o     (done)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [63:0] rr(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x};
    return d[n +: 64];
  endfunction

  function automatic type_state ref_round(input type_state s, input int i);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    type_state   r;
    x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
    x2[7:0] = x2[7:0] ^ 8'(((15 - i) << 4) | i);
    x0 ^= x4; x4 ^= x3; x2 ^= x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
    x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
    r[0] = x0 ^ rr(x0, 19) ^ rr(x0, 28);
    r[1] = x1 ^ rr(x1, 61) ^ rr(x1, 39);
    r[2] = x2 ^ rr(x2, 1)  ^ rr(x2, 6);
    r[3] = x3 ^ rr(x3, 10) ^ rr(x3, 17);
    r[4] = x4 ^ rr(x4, 7)  ^ rr(x4, 41);
    return r;
  endfunction

  function automatic type_state ref_perm(input type_state s, input int n);
    type_state r;
    r = s;
    for (int i = 12 - n; i < 12; i++) r = ref_round(r, i);
    return r;
  endfunction

  function automatic type_state rand_state();
    type_state s;
    for (int k = 0; k < 5; k++) s[k] = {$urandom(), $urandom()};
    return s;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      bcnt = 0;
      prev_done = 1'b0;
    end else begin
      if (busy) bcnt++;
      if (done) begin
        checks++;
        if (prev_done) begin
          errors++;
          $display("FAIL done_width: done high two cycles in a row, want one");
        end
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: done pulse with no job outstanding");
        end else begin
          e = q.pop_front();
          if (sout !== e.st) begin
            errors++;
            $display("FAIL result: got %h want %h", sout, e.st);
          end
          checks++;
          if (bcnt != e.n) begin
            errors++;
            $display("FAIL latency: busy cycles %0d want %0d", bcnt, e.n);
          end
        end
        bcnt = 0;
      end
      prev_done = done;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Caller positions time so the DUT is idle at the next rising edge.
  task automatic start_job(input type_state s, input bit r, input bit keep);
    start = 1'b1; r12 = r; sin = s;
    @(posedge clk);
    q.push_back('{ref_perm(s, r ? 12 : 6), r ? 12 : 6});
    if (!keep) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) return;
    end
    checks++;
    errors++;
    $display("FAIL timeout: no done within 40 cycles");
  endtask

  type_state s0, sa, sb, exp_s;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset with garbage on inputs
    rst = 1'b1; start = 1'b1; r12 = 1'b1; sin = rand_state();
    #12;
    chk("reset_state", 320'(sout), 320'(0));
    chk("reset_busy",  320'(busy), 320'(0));
    chk("reset_done",  320'(done), 320'(0));
    @(negedge clk);
    rst = 1'b0; start = 1'b0;

    // p^a on all-zero state, then hold for 5 idle cycles
    @(negedge clk);
    start_job('0, 1'b1, 1'b0);
    wait_done();
    exp_s = ref_perm('0, 12);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_state", sout, exp_s);
    end
    chk("hold_done", 320'(done), 320'(0));

    // p^b on the fixed vector
    s0[0] = 64'h0123456789ABCDEF;
    s0[1] = ~64'h0123456789ABCDEF;
    s0[2] = 64'h0;
    s0[3] = '1;
    s0[4] = 64'h8000000000000001;
    @(negedge clk);
    start_job(s0, 1'b0, 1'b0);
    wait_done();

    // start held high: second job accepted only in the done cycle
    sa = rand_state(); sb = rand_state();
    @(negedge clk);
    start_job(sa, 1'b1, 1'b1);
    @(negedge clk);
    sin = sb;
    wait_done();
    @(posedge clk);
    q.push_back('{ref_perm(sb, 12), 12});
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // reset mid p^a job, then a p^b job
    @(negedge clk);
    start_job(rand_state(), 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_state", 320'(sout), 320'(0));
    chk("abort_busy",  320'(busy), 320'(0));
    chk("abort_done",  320'(done), 320'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_job(rand_state(), 1'b0, 1'b0);
    wait_done();

    // single-round probe with x2 = 0 on a p^b job
    sa = rand_state();
    sa[2] = 64'h0;
    @(negedge clk);
    start_job(sa, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("one_round", sout, ref_round(sa, 6));
    wait_done();

    // random jobs, gap 0 means a start in the done cycle
    for (int j = 0; j < 24; j++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start_job(rand_state(), 1'($urandom_range(0, 1)), 1'b0);
      wait_done();
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", 320'(q.size()), 320'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
